// File: rtl/qspi_target.sv
// QSPI memory responder: decodes command/address/data nibbles
// and serves them from a byte-wide synchronous backing RAM.
module qspi_target #(
  parameter int PA         = 24,
  parameter int READ_DUMMY = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic [3:0]    io_in,
  output logic [3:0]    io_out,
  output logic          io_oe,
  output logic          quad_mode,
  output logic [PA-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_t;

  state_t        r_st;
  state_t        w_nxt;
  logic [7:0]    r_cmd;
  logic [3:0]    r_cnt;
  logic          r_rd;
  logic          r_quad;
  logic [19:0]   r_ash;
  logic [PA-1:0] r_addr;
  logic          r_ph;
  logic [3:0]    r_lo;
  logic [3:0]    r_wbuf;
  logic [7:0]    r_wdata;
  logic          r_we;
  logic          r_re;
  logic          r_oe;
  logic [3:0]    r_out;

  logic [7:0]    w_cmd;
  logic          w_cmd_last;
  logic          w_cmd_rw;
  logic [23:0]   w_ash;
  logic [PA-1:0] w_addr_inc;

  assign w_cmd = r_quad ? {r_cmd[3:0], io_in}
                        : {r_cmd[6:0], io_in[0]};
  assign w_cmd_last = r_quad ? (r_cnt == 4'd1)
                             : (r_cnt == 4'd7);
  assign w_cmd_rw = (w_cmd == 8'h38) ||
                    (w_cmd == 8'hEB);
  assign w_ash      = {r_ash, io_in};
  assign w_addr_inc = r_addr + PA'(1);

  assign io_out    = r_out;
  assign io_oe     = r_oe;
  assign quad_mode = r_quad;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_re    = r_re;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_st <= S_IDLE;
    else       r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    if (cs_n) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_st)
        S_IDLE: w_nxt = S_CMD;
        S_CMD: begin
          if (w_cmd_last)
            w_nxt = w_cmd_rw ? S_ADDR : S_IGNORE;
        end
        S_ADDR: begin
          if (r_cnt == 4'd5)
            w_nxt = r_rd ? S_DUMMY : S_WDATA;
        end
        S_DUMMY: begin
          if (r_cnt == 4'd1) w_nxt = S_RDATA;
        end
        default: w_nxt = r_st;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd   <= '0;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_quad  <= 1'b0;
      r_ash   <= '0;
      r_addr  <= '0;
      r_ph    <= 1'b0;
      r_lo    <= '0;
      r_wbuf  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_oe    <= 1'b0;
      r_out   <= '0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      if (cs_n) begin
        r_oe <= 1'b0;
        r_ph <= 1'b0;
      end else begin
        case (r_st)
          S_IDLE: begin
            r_cmd <= w_cmd;
            r_cnt <= 4'd1;
          end
          S_CMD: begin
            r_cmd <= w_cmd;
            r_cnt <= r_cnt + 4'd1;
            if (w_cmd_last) begin
              r_cnt <= '0;
              r_rd  <= (w_cmd == 8'hEB);
              if (w_cmd == 8'h35) r_quad <= 1'b1;
              if (w_cmd == 8'hF5) r_quad <= 1'b0;
            end
          end
          S_ADDR: begin
            r_ash  <= w_ash[19:0];
            r_addr <= w_ash[PA-1:0];
            r_cnt  <= r_cnt + 4'd1;
            if (r_cnt == 4'd5) begin
              r_ph <= 1'b0;
              if (r_rd) begin
                r_re  <= 1'b1;
                r_cnt <= 4'(READ_DUMMY);
              end
            end
          end
          S_DUMMY: begin
            r_cnt <= r_cnt - 4'd1;
            // last dummy edge: drive high nibble, prefetch next byte
            if (r_cnt == 4'd1) begin
              r_oe   <= 1'b1;
              r_out  <= mem_rdata[7:4];
              r_lo   <= mem_rdata[3:0];
              r_re   <= 1'b1;
              r_addr <= w_addr_inc;
              r_ph   <= 1'b0;
            end
          end
          S_RDATA: begin
            if (!r_ph) begin
              r_out <= r_lo;
              r_ph  <= 1'b1;
            end else begin
              r_out  <= mem_rdata[7:4];
              r_lo   <= mem_rdata[3:0];
              r_re   <= 1'b1;
              r_addr <= w_addr_inc;
              r_ph   <= 1'b0;
            end
          end
          S_WDATA: begin
            if (!r_ph) begin
              r_wbuf <= io_in;
              r_ph   <= 1'b1;
              if (r_we) r_addr <= w_addr_inc;
            end else begin
              r_wdata <= {r_wbuf, io_in};
              r_we    <= 1'b1;
              r_ph    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Randomized bench for qspi_target against a
// transaction-level model of the QSPI protocol.
module tb_qspi_target;
  localparam int PA = 24;
  localparam int RD = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs_n;
  logic [3:0]    io_in;
  logic [3:0]    io_out;
  logic          io_oe;
  logic          quad_mode;
  logic [PA-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata = 8'h00;

  qspi_target #(.PA(PA), .READ_DUMMY(RD)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .quad_mode(quad_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit mq = 1'b0;
  logic [7:0] ram [logic [23:0]];
  logic [7:0] mdl [logic [23:0]];
  logic [7:0] wq [$];

  function automatic logic [7:0] dflt(logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(logic [23:0] a);
    if (ram.exists(a)) return ram[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] mdl_rd(logic [23:0] a);
    if (mdl.exists(a)) return mdl[a];
    return dflt(a);
  endfunction

  always @(posedge clk)
    if (mem_re) mem_rdata <= ram_rd(mem_addr);

  always @(posedge clk)
    if (mem_we) ram[mem_addr] = mem_wdata;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input logic cs, input logic [3:0] nib);
    cs_n  = cs;
    io_in = nib;
    @(posedge clk);
    #1;
  endtask

  task automatic deselect();
    cyc(1'b1, 4'($urandom));
    chk("oe_desel", 32'(io_oe), 32'(0));
    chk("we_desel", 32'(mem_we), 32'(0));
    chk("quad", 32'(quad_mode), 32'(mq));
  endtask

  task automatic send_cmd(input logic [7:0] c);
    if (mq) begin
      cyc(1'b0, c[7:4]);
      chk("oe_cmd", 32'(io_oe), 32'(0));
      cyc(1'b0, c[3:0]);
      chk("oe_cmd", 32'(io_oe), 32'(0));
    end else begin
      for (int i = 7; i >= 0; i--) begin
        cyc(1'b0, {3'($urandom), c[i]});
        chk("oe_cmd", 32'(io_oe), 32'(0));
      end
    end
    if (c == 8'h35) mq = 1'b1;
    if (c == 8'hF5) mq = 1'b0;
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) begin
      cyc(1'b0, a[i*4 +: 4]);
      chk("oe_addr", 32'(io_oe), 32'(0));
    end
  endtask

  task automatic do_read(input logic [23:0] a,
                         input int nb);
    logic [23:0] aa;
    logic [7:0]  b;
    logic [3:0]  e;
    send_cmd(8'hEB);
    send_addr(a);
    chk("re_A", 32'({mem_re, mem_addr}),
        32'({1'b1, a}));
    for (int i = 0; i < RD; i++) begin
      cyc(1'b0, 4'($urandom));
      if (i < RD - 1)
        chk("oe_dummy", 32'(io_oe), 32'(0));
    end
    for (int k = 0; k < 2 * nb; k++) begin
      aa = a + 24'(k / 2);
      b  = mdl_rd(aa);
      e  = (k % 2 == 1) ? b[3:0] : b[7:4];
      chk("oe_rd", 32'(io_oe), 32'(1));
      chk("rd_nib", 32'(io_out), 32'(e));
      if (k < 2 * nb - 1) cyc(1'b0, 4'($urandom));
    end
    deselect();
  endtask

  task automatic do_write(input logic [23:0] a,
                          input bit partial);
    logic [23:0] aa;
    logic [7:0]  d;
    send_cmd(8'h38);
    send_addr(a);
    for (int i = 0; i < wq.size(); i++) begin
      d  = wq[i];
      aa = a + 24'(i);
      cyc(1'b0, d[7:4]);
      chk("we_hi", 32'(mem_we), 32'(0));
      cyc(1'b0, d[3:0]);
      chk("we", 32'(mem_we), 32'(1));
      chk("waddr", 32'(mem_addr), 32'(aa));
      chk("wdata", 32'(mem_wdata), 32'(d));
      chk("oe_wr", 32'(io_oe), 32'(0));
      mdl[aa] = d;
    end
    if (partial) begin
      cyc(1'b0, 4'($urandom));
      chk("we_part", 32'(mem_we), 32'(0));
    end
    deselect();
  endtask

  task automatic do_misc(input logic [7:0] c);
    send_cmd(c);
    repeat (3) begin
      cyc(1'b0, 4'($urandom));
      chk("oe_ign", 32'(io_oe), 32'(0));
    end
    deselect();
  endtask

  task automatic rand_write(input logic [23:0] a,
                            input bit partial);
    int nb;
    nb = $urandom_range(1, 4);
    wq.delete();
    for (int i = 0; i < nb; i++) wq.push_back(8'($urandom));
    do_write(a, partial);
  endtask

  initial begin
    logic [23:0] a;
    logic [7:0]  c;
    int          sel;
    reset = 1'b1;
    cs_n  = 1'b1;
    io_in = 4'h0;
    #12;
    chk("rst_oe", 32'(io_oe), 32'(0));
    chk("rst_out", 32'(io_out), 32'(0));
    chk("rst_quad", 32'(quad_mode), 32'(0));
    chk("rst_we", 32'(mem_we), 32'(0));
    chk("rst_re", 32'(mem_re), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 4'h0);

    for (int i = 0; i < 64; i++) begin
      a = 24'($urandom);
      ram[a] = 8'($urandom);
      mdl[a] = ram[a];
    end
    ram[24'hFFFFFF] = 8'h9C;  mdl[24'hFFFFFF] = 8'h9C;
    ram[24'h000000] = 8'h5E;  mdl[24'h000000] = 8'h5E;

    do_misc(8'h35);
    chk("quad_on", 32'(quad_mode), 32'(1));
    do_misc(8'hF5);
    chk("quad_off", 32'(quad_mode), 32'(0));
    do_misc(8'hAB);
    chk("quad_ab", 32'(quad_mode), 32'(0));
    do_misc(8'h35);

    wq = '{8'h12, 8'h34};
    do_write(24'h000010, 1'b0);
    do_read(24'h000010, 2);
    do_read(24'hFFFFFF, 2);
    wq = '{8'hAB};
    do_write(24'h000020, 1'b1);
    do_read(24'h000020, 1);
    do_read(24'h000021, 1);

    send_cmd(8'hEB);
    send_addr(24'h000010);
    for (int i = 0; i < RD + 3; i++) cyc(1'b0, 4'h0);
    chk("oe_pre_rst", 32'(io_oe), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("arst_oe", 32'(io_oe), 32'(0));
    chk("arst_quad", 32'(quad_mode), 32'(0));
    chk("arst_re", 32'(mem_re), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    mq = 1'b0;
    cyc(1'b1, 4'h0);
    do_read(24'h000010, 2);

    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 5);
      a = ($urandom_range(0, 2) == 0) ?
          24'hFFFFFF - 24'($urandom_range(0, 3)) :
          24'($urandom);
      case (sel)
        0: do_read(a, $urandom_range(1, 4));
        1: rand_write(a, 1'($urandom));
        2: begin
          c = 8'($urandom);
          if (c == 8'h38 || c == 8'hEB) c = 8'hAB;
          do_misc(c);
        end
        3: do_misc(8'h35);
        4: do_misc(8'hF5);
        default: begin
          send_cmd(8'hEB);
          repeat ($urandom_range(1, 5))
            cyc(1'b0, 4'($urandom));
          deselect();
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/qspi_target.md
# qspi_target

Synthesizable QSPI responder: the device side of the QSPI memory bus, decoding command, address and data nibbles from a QSPI initiator and serving them from a byte-wide synchronous backing RAM. Used as an on-FPGA PSRAM/flash stand-in and as the bench responder for the system's QSPI memory controller. The bus is sampled one nibble (or one SPI bit) per `clk` edge while chip-select is low; there is no separate SCK.

## Interface
Parameters:
- `PA`, 24, address width in bits; bus address is always 6 nibbles, upper bits beyond `PA` ignored.
- `READ_DUMMY`, 6, dummy nibble cycles between last address nibble and first read data nibble; legal range 2..15.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `cs_n`  in  1  chip select, active low.
- `io_in`  in  4  bus data from initiator; SPI mode uses `io_in[0]` only.
- `io_out`  out  4  read data nibble, registered.
- `io_oe`  out  1  drive enable for all four `io_out` bits, registered.
- `quad_mode`  out  1  1 = device in QPI command mode.
- `mem_addr`  out  PA  backing RAM byte address.
- `mem_wdata`  out  8  write byte.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe; `mem_rdata` valid on the following cycle.
- `mem_rdata`  in  8  read byte.

## Operation
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE: on first edge with `cs_n`=0 capture first command bit/nibble, go CMD.
- CMD: SPI mode collects 8 bits MSB first on `io_in[0]`; quad mode collects 2 nibbles, high first. Decode on final bit/nibble:
  - 0x38 quad write -> ADDR; 0xEB quad read -> ADDR (both accepted in either mode; address/data always 4-bit).
  - 0x35 enter quad: set `quad_mode`, -> IGNORE. 0xF5 exit quad: clear `quad_mode`, -> IGNORE.
  - 0xAB power-up and any other code: no effect, -> IGNORE.
- ADDR: 6 nibbles high first into 24-bit shift register; `mem_addr` = low `PA` bits. On 6th nibble: write -> WDATA; read -> assert `mem_re` for address A, -> DUMMY with counter = `READ_DUMMY`.
- DUMMY: `io_in` ignored (mode nibbles included). Counter decrements; when last dummy cycle is sampled, register `io_oe`=1, `io_out`=`mem_rdata[7:4]`, latch low nibble.
- RDATA: alternate low nibble, then high nibble of next byte. During each high-nibble cycle pulse `mem_re` for address+1 so the byte is ready for the next high nibble. Continues until `cs_n` rises.
- WDATA: nibble pairs high first; on low nibble pulse `mem_we` with assembled byte at current address, then increment address.
- Address increment wraps modulo 2^`PA`.
- IGNORE: do nothing until `cs_n` rises.
- Any state, `cs_n` sampled 1: next state IDLE, `io_oe`=0, partial write byte discarded, no `mem_we`; `quad_mode` retained.

## Timing
- Reset values: `io_oe`=0, `io_out`=0, `quad_mode`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, state IDLE.
- Cycle n = n-th edge sampling `cs_n`=0 since last deselect. Quad command: cycles 0-1; address 2-7; read dummy 8..7+`READ_DUMMY`; first read nibble (high of byte A) driven during cycle 8+`READ_DUMMY`. SPI-mode command shifts all indices by +6.
- `mem_re` for A asserted in the cycle after cycle 7 sampled; `mem_rdata` used one cycle later; `READ_DUMMY`>=2 guarantees arrival.
- Write: first `mem_we` one cycle after cycle 9 sampled (quad mode), then every 2 cycles.
- `io_oe` falls on the edge that samples `cs_n`=1; no drive during command/address/dummy.
- `cs_n` rising mid-byte, mid-address or mid-command: abort silently; reset asserted mid-transfer: all outputs to reset values immediately.

## Test plan
- SPI 0x35 (8 bits on io[0]), deselect -> `quad_mode`=1; quad 0xF5 -> `quad_mode`=0; 0xAB -> no change, `io_oe` never 1.
- Quad write 0x38, addr 0x000010, data nibbles 1,2,3,4 -> `mem_we` twice: 0x12@0x10, 0x34@0x11.
- Quad read 0xEB addr 0x000010, RAM 0x12,0x34 -> nibbles 1,2,3,4 starting cycle 14 (default `READ_DUMMY`), `io_oe`=1 from cycle 14.
- Read at 0xFFFFFF with `PA`=24 -> second byte fetched from 0x000000.
- Write with 3 data nibbles then `cs_n` high -> one `mem_we` only, `io_oe`=0, next command decodes normally.
- Reset asserted during RDATA -> `io_oe`=0, `quad_mode`=0 asynchronously; next SPI-mode 0xEB read works.
